// File: rtl/des_engine_top.sv
// rtl/des_engine_top.sv - 17-stage pipelined single-DES encrypt/decrypt engine, one block per clock.
// Define DES_OUTPUT_REG_EN to register cipher_text after IP^-1 (latency 17 instead of 16).
module des_engine_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] cipher_key,
  input  logic [63:0] plain_text,
  input  logic        encrypt_decrypt,
  output logic [63:0] cipher_text
);

  // Tables hold DES bit numbers (1 = MSB), exactly as published.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int ENC_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int DEC_SH [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each box is 4 rows of 16, flattened as row*16 + col.
  localparam int S_T [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
    return y;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
    return y;
  endfunction

  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    logic [5:0]  idx;
    y = '0;
    for (int n = 0; n < 8; n++) begin
      b   = x[47 - 6 * n -: 6];
      idx = {b[5], b[0], b[4:1]};
      y[31 - 4 * n -: 4] = 4'(S_T[n][idx]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Index 0 is the input stage, index i holds the state after round i.
  logic [31:0] l_q     [17];
  logic [31:0] r_q     [17];
  logic [27:0] c_q     [17];
  logic [27:0] d_q     [17];
  logic        mode_q  [17];
  logic        valid_q [17];

  logic [27:0] c_n    [16];
  logic [27:0] d_n    [16];
  logic [47:0] subkey [16];
  logic [31:0] f_out  [16];

  // Decrypt walks the schedule backwards: C16 == C0, so round 1 needs no rotation.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      if (mode_q[i]) begin
        c_n[i] = rotl28(c_q[i], 2'(ENC_SH[i]));
        d_n[i] = rotl28(d_q[i], 2'(ENC_SH[i]));
      end else begin
        c_n[i] = rotr28(c_q[i], 2'(DEC_SH[i]));
        d_n[i] = rotr28(d_q[i], 2'(DEC_SH[i]));
      end
      subkey[i] = pc2_f({c_n[i], d_n[i]});
      f_out[i]  = p_f(sbox_f(e_f(r_q[i]) ^ subkey[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 17; i++) begin
        l_q[i]     <= '0;
        r_q[i]     <= '0;
        c_q[i]     <= '0;
        d_q[i]     <= '0;
        mode_q[i]  <= 1'b0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      {l_q[0], r_q[0]} <= ip_f(plain_text);
      {c_q[0], d_q[0]} <= pc1_f(cipher_key);
      mode_q[0]        <= encrypt_decrypt;
      valid_q[0]       <= 1'b1;
      for (int i = 1; i < 17; i++) begin
        l_q[i]     <= r_q[i-1];
        r_q[i]     <= l_q[i-1] ^ f_out[i-1];
        c_q[i]     <= c_n[i-1];
        d_q[i]     <= d_n[i-1];
        mode_q[i]  <= mode_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Final swap is undone by concatenating R16 ahead of L16.
  logic [63:0] result;
  assign result = fp_f({r_q[16], l_q[16]});

`ifdef DES_OUTPUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipher_text <= '0;
    end else begin
      cipher_text <= valid_q[16] ? result : 64'h0;
    end
  end
`else
  // Stale stages hold garbage after reset, so gate with valid.
  assign cipher_text = valid_q[16] ? result : 64'h0;
`endif

endmodule

// File: tb/tb_des_engine_top.sv
// tb/tb_des_engine_top.sv - randomized bench for des_engine_top against a bit-list DES reference model.
module tb_des_engine_top;

`ifdef DES_OUTPUT_REG_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int S_T [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] cipher_key = '0;
  logic [63:0] plain_text = '0;
  logic        encrypt_decrypt = 1'b0;
  logic [63:0] cipher_text;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q  [$];
  bit          kat_q  [$];
  logic [63:0] katv_q [$];
  bit          cur_kat = 1'b0;
  logic [63:0] cur_katv = '0;

  always #5 clk = ~clk;

  des_engine_top dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cipher_key      (cipher_key),
    .plain_text      (plain_text),
    .encrypt_decrypt (encrypt_decrypt),
    .cipher_text     (cipher_text)
  );

  // Textbook DES on 1-indexed bit lists: full key schedule first, subkeys reversed for decrypt.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit enc);
    bit kb [1:64];
    bit mb [1:64];
    bit xb [1:64];
    bit pre [1:64];
    bit cd [1:56];
    bit ks [1:16][1:48];
    bit lb [1:32];
    bit rb [1:32];
    bit tb [1:32];
    bit sb [1:32];
    bit eb [1:48];
    bit c0, d0;
    int kk;
    logic [5:0]  six;
    logic [5:0]  idx;
    logic [3:0]  nib;
    logic [63:0] res;
    res = '0;
    for (int i = 1; i <= 64; i++) begin
      kb[i] = key[6'(64 - i)];
      mb[i] = blk[6'(64 - i)];
    end
    for (int j = 1; j <= 56; j++) cd[j] = kb[PC1_T[j-1]];
    for (int rnd = 1; rnd <= 16; rnd++) begin
      for (int s = 0; s < SHIFTS[rnd-1]; s++) begin
        c0 = cd[1];
        d0 = cd[29];
        for (int i = 1; i < 28; i++) begin
          cd[i]    = cd[i+1];
          cd[i+28] = cd[i+29];
        end
        cd[28] = c0;
        cd[56] = d0;
      end
      for (int j = 1; j <= 48; j++) ks[rnd][j] = cd[PC2_T[j-1]];
    end
    for (int j = 1; j <= 64; j++) xb[j] = mb[IP_T[j-1]];
    for (int i = 1; i <= 32; i++) begin
      lb[i] = xb[i];
      rb[i] = xb[i+32];
    end
    for (int rnd = 1; rnd <= 16; rnd++) begin
      kk = enc ? rnd : 17 - rnd;
      for (int j = 1; j <= 48; j++) eb[j] = rb[E_T[j-1]] ^ ks[kk][j];
      for (int n = 0; n < 8; n++) begin
        six = {eb[6*n+1], eb[6*n+2], eb[6*n+3], eb[6*n+4], eb[6*n+5], eb[6*n+6]};
        idx = {six[5], six[0], six[4:1]};
        nib = 4'(S_T[n][idx]);
        sb[4*n+1] = nib[3];
        sb[4*n+2] = nib[2];
        sb[4*n+3] = nib[1];
        sb[4*n+4] = nib[0];
      end
      for (int j = 1; j <= 32; j++) tb[j] = lb[j] ^ sb[P_T[j-1]];
      lb = rb;
      rb = tb;
    end
    for (int i = 1; i <= 32; i++) begin
      pre[i]    = rb[i];
      pre[i+32] = lb[i];
    end
    for (int j = 1; j <= 64; j++) res[6'(64 - j)] = pre[FP_T[j-1]];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    kat_q.delete();
    katv_q.delete();
    for (int i = 0; i < LAT; i++) begin
      exp_q.push_back(64'h0);
      kat_q.push_back(1'b0);
      katv_q.push_back(64'h0);
    end
  endtask

  task automatic rand_in();
    cipher_key      = {$urandom(), $urandom()};
    plain_text      = {$urandom(), $urandom()};
    encrypt_decrypt = 1'($urandom_range(0, 1));
  endtask

  // One clock: model the edge, then compare #1 after it.
  task automatic tick(input string tag);
    logic [63:0] e;
    logic [63:0] kv;
    bit          k;
    @(posedge clk);
    if (!rst_n) begin
      flush_model();
      e  = 64'h0;
      k  = 1'b0;
      kv = 64'h0;
    end else begin
      exp_q.push_back(des_ref(cipher_key, plain_text, encrypt_decrypt));
      kat_q.push_back(cur_kat);
      katv_q.push_back(cur_katv);
      e  = exp_q.pop_front();
      k  = kat_q.pop_front();
      kv = katv_q.pop_front();
    end
    cur_kat = 1'b0;
    #1;
    check(tag, cipher_text, e);
    if (k) check("kat", cipher_text, kv);
  endtask

  task automatic kat(input logic [63:0] key, input logic [63:0] blk, input bit enc, input logic [63:0] expv);
    cipher_key      = key;
    plain_text      = blk;
    encrypt_decrypt = enc;
    cur_kat         = 1'b1;
    cur_katv        = expv;
    tick("kat_in");
  endtask

  initial begin
    flush_model();
    rst_n = 1'b0;
    repeat (3) begin
      rand_in();
      tick("reset");
    end
    rst_n = 1'b1;

    kat(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405);
    kat(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0, 64'h0123456789ABCDEF);
    kat(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1, 64'h0000000000000000);

    for (int i = 0; i < 40; i++) begin
      cipher_key      = 64'h133457799BBCDFF1;
      plain_text      = 64'(i);
      encrypt_decrypt = (i % 2) == 0;
      tick("b2b");
    end

    for (int i = 0; i < 150; i++) begin
      rand_in();
      tick("rand");
    end

    rst_n = 1'b0;
    #1;
    check("rst_async", cipher_text, 64'h0);
    flush_model();
    repeat (2) begin
      rand_in();
      tick("rst_hold");
    end
    rst_n = 1'b1;
    kat(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405);
    for (int i = 0; i < LAT + 40; i++) begin
      rand_in();
      tick("post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
